video_window_calc: RTL

// Consumes VIDEO_ARX/VIDEO_ARY from the aspect/crop/integer-scale stage and turns them into the output window on the HDMI raster.

---
 rtl/video_window_calc.sv | 305 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/video_window_calc.sv
// Output window calculator: sizes the scaler window from aspect/absolute inputs,
// centres it on the HDMI raster and commits new results on the rising edge of HDMI_VS.
module video_window_calc #(
    parameter bit EVEN_H = 1'b1
) (
    input  logic        CLK_VIDEO,
    input  logic        RESET,
    input  logic        HDMI_VS,
    input  logic [11:0] HDMI_WIDTH,
    input  logic [11:0] HDMI_HEIGHT,
    input  logic [12:0] ARX,
    input  logic [12:0] ARY,
    output logic [11:0] HMIN,
    output logic [11:0] HMAX,
    output logic [11:0] VMIN,
    output logic [11:0] VMAX,
    output logic        VALID
);

    localparam int unsigned DW        = 12;
    localparam int unsigned AW        = 13;
    localparam int unsigned PW        = 24;
    localparam int unsigned DIV_STEPS = 24;
    localparam int unsigned CNT_W     = 5;

    typedef enum logic [3:0] {
        S_IDLE, S_CAPTURE, S_MUL_W, S_DIV_W, S_CHECK,
        S_MUL_H, S_DIV_H, S_CENTER, S_UPDATE
    } state_t;

    state_t r_state, w_state_nxt;
    logic   r_issued, w_issued_nxt;

    logic w_mul_start, w_div_start, w_snap_ld, w_ld_direct;
    logic w_ld_chk, w_ld_divh, w_ld_ctr, w_ld_pend;

    logic [DW-1:0] r_snap_w, r_snap_h;
    logic [AW-1:0] r_snap_arx, r_snap_ary;
    logic          r_snap_vld;

    logic [DW-1:0] r_w, r_h;

    logic [DW-1:0] r_mul_a, r_mul_b;
    logic [PW-1:0] r_prod;
    logic          r_mul_run;

    logic [PW-1:0]    r_div_q;
    logic [DW-1:0]    r_div_r, r_div_d;
    logic [CNT_W-1:0] r_div_cnt;
    logic             r_div_run;
    logic [DW:0]      w_div_rs;
    logic             w_div_ge;

    logic [DW-1:0] r_c_hmin, r_c_hmax, r_c_vmin, r_c_vmax;
    logic [DW-1:0] r_p_hmin, r_p_hmax, r_p_vmin, r_p_vmax;
    logic          r_pending;

    logic [DW-1:0] r_hmin, r_hmax, r_vmin, r_vmax;
    logic          r_valid;
    logic          r_vs_d;

    logic          w_mismatch, w_direct, w_wc_fits, w_vs_rise, w_commit;
    logic [DW-1:0] w_abs_w, w_abs_h, w_dir_w, w_dir_h, w_hc_h;
    logic [AW-1:0] w_hdiff, w_vdiff, w_hmin, w_vmin, w_hmax, w_vmax;

    // Input snapshot comparison and direct (stretch/absolute) sizing
    always_comb begin
        w_mismatch = !r_snap_vld || (ARX != r_snap_arx) || (ARY != r_snap_ary) ||
                     (HDMI_WIDTH != r_snap_w) || (HDMI_HEIGHT != r_snap_h);
        w_direct   = ARX[12] || (ARX[11:0] == 12'd0) || (ARY[11:0] == 12'd0);
        w_abs_w    = (ARX[11:0] == 12'd0) ? HDMI_WIDTH  : ARX[11:0];
        w_abs_h    = (ARY[11:0] == 12'd0) ? HDMI_HEIGHT : ARY[11:0];
        w_dir_w    = HDMI_WIDTH;
        w_dir_h    = HDMI_HEIGHT;
        if (ARX[12]) begin
            w_dir_w = (w_abs_w > HDMI_WIDTH)  ? HDMI_WIDTH  : w_abs_w;
            w_dir_h = (w_abs_h > HDMI_HEIGHT) ? HDMI_HEIGHT : w_abs_h;
        end
        w_wc_fits = (r_div_q <= PW'(r_snap_w));
        w_hc_h    = (r_div_q < PW'(r_snap_h)) ? r_div_q[DW-1:0] : r_snap_h;
    end

    // Centring arithmetic, 13 bits wide
    always_comb begin
        w_hdiff = AW'(r_snap_w) - AW'(r_w);
        w_vdiff = AW'(r_snap_h) - AW'(r_h);
        w_hmin  = {1'b0, w_hdiff[AW-1:1]};
        w_vmin  = {1'b0, w_vdiff[AW-1:1]};
        if (EVEN_H) begin
            w_hmin[0] = 1'b0;
        end
        w_hmax  = w_hmin + AW'(r_w) - AW'(1);
        w_vmax  = w_vmin + AW'(r_h) - AW'(1);
    end

    always_ff @(posedge CLK_VIDEO) begin
        if (RESET) begin
            r_state  <= S_IDLE;
            r_issued <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_issued <= w_issued_nxt;
        end
    end

    // Sequencer: each arithmetic state issues one start, then waits for the unit to go idle
    always_comb begin
        w_state_nxt  = r_state;
        w_issued_nxt = r_issued;
        w_mul_start  = 1'b0;
        w_div_start  = 1'b0;
        w_snap_ld    = 1'b0;
        w_ld_direct  = 1'b0;
        w_ld_chk     = 1'b0;
        w_ld_divh    = 1'b0;
        w_ld_ctr     = 1'b0;
        w_ld_pend    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mismatch) w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_snap_ld = 1'b1;
                if (w_direct) begin
                    w_ld_direct = 1'b1;
                    w_state_nxt = S_CENTER;
                end else begin
                    w_state_nxt = S_MUL_W;
                end
            end
            S_MUL_W, S_MUL_H: begin
                if (!r_issued) begin
                    if (!r_mul_run) begin
                        w_mul_start  = 1'b1;
                        w_issued_nxt = 1'b1;
                    end
                end else if (!r_mul_run) begin
                    w_issued_nxt = 1'b0;
                    w_state_nxt  = (r_state == S_MUL_W) ? S_DIV_W : S_DIV_H;
                end
            end
            S_DIV_W, S_DIV_H: begin
                if (!r_issued) begin
                    if (!r_div_run) begin
                        w_div_start  = 1'b1;
                        w_issued_nxt = 1'b1;
                    end
                end else if (!r_div_run) begin
                    w_issued_nxt = 1'b0;
                    if (r_state == S_DIV_W) begin
                        w_state_nxt = S_CHECK;
                    end else begin
                        w_ld_divh   = 1'b1;
                        w_state_nxt = S_CENTER;
                    end
                end
            end
            S_CHECK: begin
                if (w_wc_fits) begin
                    w_ld_chk    = 1'b1;
                    w_state_nxt = S_CENTER;
                end else begin
                    w_state_nxt = S_MUL_H;
                end
            end
            S_CENTER: begin
                w_ld_ctr    = 1'b1;
                w_state_nxt = S_UPDATE;
            end
            S_UPDATE: begin
                w_ld_pend   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Shared multiplier: operands latched on start, product one cycle later
    always_ff @(posedge CLK_VIDEO) begin
        if (RESET) begin
            r_mul_a   <= '0;
            r_mul_b   <= '0;
            r_prod    <= '0;
            r_mul_run <= 1'b0;
        end else if (w_mul_start) begin
            r_mul_a   <= (r_state == S_MUL_W) ? r_snap_h : r_snap_w;
            r_mul_b   <= (r_state == S_MUL_W) ? r_snap_arx[DW-1:0] : r_snap_ary[DW-1:0];
            r_mul_run <= 1'b1;
        end else if (r_mul_run) begin
            r_prod    <= PW'(r_mul_a) * PW'(r_mul_b);
            r_mul_run <= 1'b0;
        end
    end

    always_comb begin
        w_div_rs = {r_div_r, r_div_q[PW-1]};
        w_div_ge = (w_div_rs >= {1'b0, r_div_d});
    end

    // Restoring divider, one quotient bit per cycle; quotient shifts in behind the dividend
    always_ff @(posedge CLK_VIDEO) begin
        if (RESET) begin
            r_div_q   <= '0;
            r_div_r   <= '0;
            r_div_d   <= '0;
            r_div_cnt <= '0;
            r_div_run <= 1'b0;
        end else if (w_div_start) begin
            r_div_q   <= r_prod;
            r_div_r   <= '0;
            r_div_d   <= (r_state == S_DIV_W) ? r_snap_ary[DW-1:0] : r_snap_arx[DW-1:0];
            r_div_cnt <= CNT_W'(DIV_STEPS);
            r_div_run <= 1'b1;
        end else if (r_div_run) begin
            r_div_r   <= w_div_ge ? DW'(w_div_rs - {1'b0, r_div_d}) : DW'(w_div_rs);
            r_div_q   <= {r_div_q[PW-2:0], w_div_ge};
            r_div_cnt <= r_div_cnt - CNT_W'(1);
            if (r_div_cnt == CNT_W'(1)) r_div_run <= 1'b0;
        end
    end

    always_comb begin
        w_vs_rise = HDMI_VS && !r_vs_d;
        w_commit  = w_vs_rise && r_pending;
    end

    // Snapshot, window size, pending result and committed outputs
    always_ff @(posedge CLK_VIDEO) begin
        if (RESET) begin
            r_snap_w   <= '0;
            r_snap_h   <= '0;
            r_snap_arx <= '0;
            r_snap_ary <= '0;
            r_snap_vld <= 1'b0;
            r_w        <= '0;
            r_h        <= '0;
            r_c_hmin   <= '0;
            r_c_hmax   <= '0;
            r_c_vmin   <= '0;
            r_c_vmax   <= '0;
            r_p_hmin   <= '0;
            r_p_hmax   <= '0;
            r_p_vmin   <= '0;
            r_p_vmax   <= '0;
            r_pending  <= 1'b0;
            r_hmin     <= '0;
            r_hmax     <= '0;
            r_vmin     <= '0;
            r_vmax     <= '0;
            r_valid    <= 1'b0;
            r_vs_d     <= 1'b0;
        end else begin
            r_vs_d <= HDMI_VS;
            if (w_snap_ld) begin
                r_snap_w   <= HDMI_WIDTH;
                r_snap_h   <= HDMI_HEIGHT;
                r_snap_arx <= ARX;
                r_snap_ary <= ARY;
                r_snap_vld <= 1'b1;
            end
            if (w_ld_direct) begin
                r_w <= w_dir_w;
                r_h <= w_dir_h;
            end else if (w_ld_chk) begin
                r_w <= r_div_q[DW-1:0];
                r_h <= r_snap_h;
            end else if (w_ld_divh) begin
                r_w <= r_snap_w;
                r_h <= w_hc_h;
            end
            if (w_ld_ctr) begin
                r_c_hmin <= DW'(w_hmin);
                r_c_hmax <= DW'(w_hmax);
                r_c_vmin <= DW'(w_vmin);
                r_c_vmax <= DW'(w_vmax);
            end
            if (w_ld_pend) begin
                r_p_hmin <= r_c_hmin;
                r_p_hmax <= r_c_hmax;
                r_p_vmin <= r_c_vmin;
                r_p_vmax <= r_c_vmax;
            end
            // A new result landing on a VS edge stays pending; the commit takes the older one
            if (w_ld_pend) begin
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
            if (w_commit) begin
                r_hmin  <= r_p_hmin;
                r_hmax  <= r_p_hmax;
                r_vmin  <= r_p_vmin;
                r_vmax  <= r_p_vmax;
                r_valid <= 1'b1;
            end
        end
    end

    assign HMIN  = r_hmin;
    assign HMAX  = r_hmax;
    assign VMIN  = r_vmin;
    assign VMAX  = r_vmax;
    assign VALID = r_valid;

endmodule
